// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder
// ----------------------------------------------------------------------------
// Memory-side responder for the core's data-memory interface. It accepts one
// request at a time and holds it for a programmable number of wait states.
// It then returns a single-cycle ready pulse that carries read data or an
// error flag. The core holds mem_read/mem_write until it sees ready, and must
// drop them on that cycle. A request still asserted at the next edge (the
// single IDLE cycle after RESP) is taken as a new request.
//
// Parameters
//   ADDR_W       word-address width; storage is 2**ADDR_W words of 32 bits.
//                Must be 1..29 so that the out-of-range field exists.
//   WAIT_CYCLES  wait states between acceptance and response, 0..15
//
// Ports
//   clk        in   1   system clock, all state updates on the rising edge
//   rst        in   1   synchronous active-high reset
//   mem_read   in   1   read request, held until ready
//   mem_write  in   1   write request, held until ready
//   address    in  32   byte address; word index is address[ADDR_W+1:2]
//   wdata      in  32   write data, sampled at acceptance
//   rdata      out 32   read data while ready=1 for a good read, else 0
//   ready      out  1   one-cycle completion pulse
//   err        out  1   request rejected (asserted together with ready)
//   busy       out  1   request in flight (WAIT or RESP)
//
// Build option
//   MISALIGN_CHECK_EN  when defined, a nonzero address[1:0] at acceptance is
//                      rejected with err. When undefined, address[1:0] is
//                      ignored.
//
// Timing
//   Request sampled at edge N: the FSM enters RESP at edge N+WAIT_CYCLES.
//   ready is high for the one cycle that follows that edge.
//
// Storage
//   The array is written synchronously and read through a register, so it
//   maps onto block RAM. The read port runs every cycle. In IDLE it is
//   addressed from the live address bus, so a zero-wait read gets its data
//   at the acceptance edge. In WAIT/RESP it uses the latched index. Either
//   way, the data register holds the right word by the time the FSM is in
//   RESP.
// ============================================================================
`timescale 1ns/1ps

module data_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic                r_is_write;
    logic                r_err;
    logic [ADDR_W-1:0]   r_index;
    logic [31:0]         r_wdata;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]         r_mem [0:DEPTH-1];
    logic [31:0]         r_mem_q;

    // ------------------------------------------------------------------
    // Request decode (only meaningful while in IDLE)
    // ------------------------------------------------------------------
    logic                w_req;
    logic [ADDR_W-1:0]   w_index_in;
    logic                w_out_of_range;
    logic                w_conflict;
    logic                w_misalign;
    logic                w_req_err;
    logic [ADDR_W-1:0]   w_rd_index;
    logic                w_mem_we;

    assign w_req      = mem_read | mem_write;
    assign w_index_in = address[ADDR_W+1:2];
    assign w_conflict = mem_read & mem_write;

    // Any set bit above the word-index field addresses storage that does
    // not exist.
    assign w_out_of_range = ((address >> (ADDR_W + 2)) != 32'd0);

`ifdef MISALIGN_CHECK_EN
    assign w_misalign = |address[1:0];
`else
    // The byte offset is ignored. The parity keeps the two low bits
    // referenced so that they do not appear as dangling inputs.
    logic w_unused_byte_offset;
    assign w_unused_byte_offset = ^address[1:0];
    assign w_misalign           = 1'b0;
`endif

    assign w_req_err = w_conflict | w_out_of_range | w_misalign;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // The counter is loaded with WAIT_CYCLES. The edge that takes
                // it from 1 to 0 is the edge that enters RESP, so WAIT lasts
                // exactly WAIT_CYCLES cycles. The <= also catches a counter
                // that is already 0, so the FSM cannot stay in WAIT forever.
                if (r_cnt <= 4'd1) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        err   = 1'b0;
        busy  = 1'b0;
        rdata = 32'd0;
        case (r_state)
            S_WAIT: begin
                busy = 1'b1;
            end
            S_RESP: begin
                busy  = 1'b1;
                ready = 1'b1;
                err   = r_err;
                if (!r_is_write && !r_err) begin
                    rdata = r_mem_q;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counter and request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
            r_index    <= '0;
            r_wdata    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_cnt      <= WAIT_INIT;
                        r_is_write <= mem_write;
                        r_err      <= w_req_err;
                        r_index    <= w_index_in;
                        r_wdata    <= wdata;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Block RAM
    // ------------------------------------------------------------------
    assign w_rd_index = (r_state == S_IDLE) ? w_index_in : r_index;

    // The write commits at the end of RESP. A reset asserted in that same
    // cycle discards it.
    assign w_mem_we = (r_state == S_RESP) & r_is_write & ~r_err & ~rst;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_index] <= r_wdata;
        end
        r_mem_q <= r_mem[w_rd_index];
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder
// ----------------------------------------------------------------------------
// Directed bench for data_mem_responder. It uses two instances:
//   dut2 - WAIT_CYCLES=2 (default), used for most steps
//   dut0 - WAIT_CYCLES=0, used for the zero-wait steps
// Both instances share the input buses. The request strobes are steered to
// one instance at a time by 'sel'.
// ============================================================================
`timescale 1ns/1ps

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;            // 0 -> dut2, 1 -> dut0
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] wdata;

    logic [31:0] rdata2, rdata0;
    logic        ready2, ready0, err2, err0, busy2, busy0;

    logic        rd2, wr2, rd0, wr0;
    assign rd2 = mem_read  & ~sel;
    assign wr2 = mem_write & ~sel;
    assign rd0 = mem_read  &  sel;
    assign wr0 = mem_write &  sel;

    logic [31:0] t_rdata;
    logic        t_ready, t_err, t_busy;
    assign t_rdata = sel ? rdata0 : rdata2;
    assign t_ready = sel ? ready0 : ready2;
    assign t_err   = sel ? err0   : err2;
    assign t_busy  = sel ? busy0  : busy2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(16), .WAIT_CYCLES(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (rd2),
        .mem_write (wr2),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata2),
        .ready     (ready2),
        .err       (err2),
        .busy      (busy2)
    );

    data_mem_responder #(.ADDR_W(16), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (rd0),
        .mem_write (wr0),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata0),
        .ready     (ready0),
        .err       (err0),
        .busy      (busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge and wait (bounded) for ready. lat is
    // the number of negedges after the acceptance edge at which ready was
    // first seen (equals WAIT_CYCLES), or -1 on timeout. It returns at a
    // negedge with the responder back in IDLE and the strobes low.
    task automatic access(input logic use0, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic o_err, output logic [31:0] o_rdata);
        lat     = -1;
        o_err   = 1'bx;
        o_rdata = 32'hxxxx_xxxx;
        sel       = use0;
        mem_read  = rd;
        mem_write = wr;
        address   = addr;
        wdata     = wd;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t_ready) begin
                lat     = i;
                o_err   = t_err;
                o_rdata = t_rdata;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        $display("req dut%0d rd=%0b wr=%0b addr=0x%08h wdata=0x%08h -> lat=%0d err=%0b rdata=0x%08h",
                 use0 ? 0 : 2, rd, wr, addr, wd, lat, o_err, o_rdata);
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] d;
        int          pulses;

        rst = 1'b1; sel = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = 32'd0; wdata = 32'd0;

        // 1. Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready2", {31'd0, ready2}, 32'd0);
        check("reset_err2",   {31'd0, err2},   32'd0);
        check("reset_busy2",  {31'd0, busy2},  32'd0);
        check("reset_rdata2", rdata2,          32'd0);
        check("reset_ready0", {31'd0, ready0}, 32'd0);
        check("reset_busy0",  {31'd0, busy0},  32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready2 || ready0 || busy2 || busy0) pulses++;
        end
        check("idle_no_activity", pulses, 0);
        $display("reset + 10 idle cycles: activity=%0d", pulses);

        // Preload words used later
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'h1111_1111, lat, e, d);
        check("pre20_err", {31'd0, e}, 32'd0);
        access(1'b0, 1'b0, 1'b1, 32'h00, 32'h0BAD_F00D, lat, e, d);
        check("pre00_err", {31'd0, e}, 32'd0);
        access(1'b0, 1'b0, 1'b1, 32'h30, 32'hAAAA_AAAA, lat, e, d);
        check("pre30_err", {31'd0, e}, 32'd0);

        // 2. Write then read, WAIT_CYCLES=2
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, e, d);
        check("wr10_lat", lat, 2);
        check("wr10_err", {31'd0, e}, 32'd0);
        check("wr10_rdata", d, 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, e, d);
        check("rd10_lat", lat, 2);
        check("rd10_err", {31'd0, e}, 32'd0);
        check("rd10_rdata", d, 32'hDEAD_BEEF);
        check("idle_rdata_zero", rdata2, 32'd0);

        // 3. Conflicting request
        access(1'b0, 1'b1, 1'b1, 32'h20, 32'h5, lat, e, d);
        check("conf_lat", lat, 2);
        check("conf_err", {31'd0, e}, 32'd1);
        check("conf_rdata", d, 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, e, d);
        check("rd20_rdata", d, 32'h1111_1111);

        // 4. Out of range
        access(1'b0, 1'b0, 1'b1, 32'h0004_0000, 32'hCAFE_F00D, lat, e, d);
        check("oor_wr_lat", lat, 2);
        check("oor_wr_err", {31'd0, e}, 32'd1);
        access(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, lat, e, d);
        check("oor_rd_err", {31'd0, e}, 32'd1);
        check("oor_rd_rdata", d, 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h00, 32'h0, lat, e, d);
        check("rd00_err", {31'd0, e}, 32'd0);
        check("rd00_rdata", d, 32'h0BAD_F00D);
        // Top word of the address space is in range
        access(1'b0, 1'b0, 1'b1, 32'h0003_FFFC, 32'h600D_CAFE, lat, e, d);
        check("top_wr_err", {31'd0, e}, 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h0003_FFFC, 32'h0, lat, e, d);
        check("top_rd_rdata", d, 32'h600D_CAFE);

        // 5. Reset mid-write
        sel = 1'b0; mem_write = 1'b1; address = 32'h30; wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        check("midwr_busy_wait", {31'd0, busy2}, 32'd1);
        rst = 1'b1; mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midwr_busy_rst", {31'd0, busy2}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready2) pulses++;
        end
        check("midwr_no_ready", pulses, 0);
        $display("reset mid-write: ready pulses=%0d", pulses);
        access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, lat, e, d);
        check("rd30_rdata", d, 32'hAAAA_AAAA);

        // 6. Zero wait, read-after-write, byte offset
        access(1'b1, 1'b0, 1'b1, 32'h10, 32'h55AA_1234, lat, e, d);
        check("z_wr_lat", lat, 0);
        check("z_wr_err", {31'd0, e}, 32'd0);
        access(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, lat, e, d);
        check("z_rd_lat", lat, 0);
        check("z_rd_rdata", d, 32'h55AA_1234);
        access(1'b1, 1'b1, 1'b0, 32'h12, 32'h0, lat, e, d);
`ifdef MISALIGN_CHECK_EN
        check("z_mis_err", {31'd0, e}, 32'd1);
        check("z_mis_rdata", d, 32'd0);
`else
        check("z_mis_err", {31'd0, e}, 32'd0);
        check("z_mis_rdata", d, 32'h55AA_1234);
`endif
        access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, lat, e, d);
`ifdef MISALIGN_CHECK_EN
        check("w2_mis_err", {31'd0, e}, 32'd1);
        check("w2_mis_rdata", d, 32'd0);
`else
        check("w2_mis_err", {31'd0, e}, 32'd0);
        check("w2_mis_rdata", d, 32'hDEAD_BEEF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
